// File: rtl/game_round_controller.sv
// Round sequencer for the target/torpedo game: sprite load/launch,
// shot accounting, win/loss decision, saturating score and timer start.
module game_round_controller #(
  parameter int N_SHOTS     = 3,
  parameter int SHOT_WIDTH  = 2,
  parameter int SCORE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  input  logic                   sprite_target_within_screen,
  input  logic                   sprite_torpedo_within_screen,
  input  logic                   collision,
  input  logic                   end_of_game_timer_running,
  output logic                   sprite_target_write_xy,
  output logic                   sprite_target_write_dxy,
  output logic                   sprite_torpedo_write_xy,
  output logic                   sprite_torpedo_write_dxy,
  output logic                   sprite_target_enable_update,
  output logic                   sprite_torpedo_enable_update,
  output logic                   end_of_game_timer_start,
  output logic                   game_won,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [SHOT_WIDTH-1:0]  shots_left
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] LOAD    = 4'd1;
  localparam logic [3:0] AIM     = 4'd2;
  localparam logic [3:0] FIRE    = 4'd3;
  localparam logic [3:0] FLIGHT  = 4'd4;
  localparam logic [3:0] RELOAD  = 4'd5;
  localparam logic [3:0] WON     = 4'd6;
  localparam logic [3:0] LOST    = 4'd7;
  localparam logic [3:0] END_RND = 4'd8;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       key_d;
  logic       key_fire;
  logic       seen_run;
  logic       timer_done;

  assign key_fire   = key & ~key_d;
  assign timer_done = seen_run & ~end_of_game_timer_running;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (key_fire) state_nxt = LOAD;
      LOAD:    state_nxt = AIM;
      AIM: begin
        if (!sprite_target_within_screen) state_nxt = LOST;
        else if (key_fire)                state_nxt = FIRE;
      end
      FIRE:    state_nxt = FLIGHT;
      FLIGHT: begin
        if (collision)                         state_nxt = WON;
        else if (!sprite_target_within_screen) state_nxt = LOST;
        else if (!sprite_torpedo_within_screen)
          state_nxt = (shots_left != '0) ? RELOAD : LOST;
      end
      RELOAD:  state_nxt = AIM;
      WON:     state_nxt = END_RND;
      LOST:    state_nxt = END_RND;
      END_RND: if (timer_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore decode: every strobe lasts exactly one state cycle
  always_comb begin
    sprite_target_write_xy       = 1'b0;
    sprite_target_write_dxy      = 1'b0;
    sprite_torpedo_write_xy      = 1'b0;
    sprite_torpedo_write_dxy     = 1'b0;
    sprite_target_enable_update  = 1'b0;
    sprite_torpedo_enable_update = 1'b0;
    end_of_game_timer_start      = 1'b0;
    unique case (1'b1)
      state == LOAD: begin
        sprite_target_write_xy   = 1'b1;
        sprite_target_write_dxy  = 1'b1;
        sprite_torpedo_write_xy  = 1'b1;
        sprite_torpedo_write_dxy = 1'b1;
      end
      state == AIM:
        sprite_target_enable_update = 1'b1;
      state == FIRE: begin
        sprite_torpedo_write_dxy    = 1'b1;
        sprite_target_enable_update = 1'b1;
      end
      state == FLIGHT: begin
        sprite_target_enable_update  = 1'b1;
        sprite_torpedo_enable_update = 1'b1;
      end
      state == RELOAD: begin
        sprite_torpedo_write_xy     = 1'b1;
        sprite_target_enable_update = 1'b1;
      end
      state == WON, state == LOST:
        end_of_game_timer_start = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      key_d      <= 1'b0;
      seen_run   <= 1'b0;
      score      <= '0;
      shots_left <= '0;
      game_won   <= 1'b0;
    end else begin
      state <= state_nxt;
      key_d <= key;
      if (state == LOAD) begin
        shots_left <= SHOT_WIDTH'(N_SHOTS);
        game_won   <= 1'b0;
      end
      if (state == FIRE && shots_left != '0)
        shots_left <= shots_left - SHOT_WIDTH'(1);
      if (state == WON) begin
        game_won <= 1'b1;
        if (score != '1) score <= score + SCORE_WIDTH'(1);
      end
      if (state == LOST)
        game_won <= 1'b0;
      // Wait for the timer to have been seen busy before trusting its low level
      if (state == END_RND)
        seen_run <= timer_done ? 1'b0
                               : (seen_run | end_of_game_timer_running);
    end
  end

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench for game_round_controller: directed rounds push
// expected events, monitors pop them when the DUT strobes.
module tb_game_round_controller;

  localparam int NS = 3;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       key   = 1'b0;
  logic       tw    = 1'b1;
  logic       pw    = 1'b1;
  logic       coll  = 1'b0;
  logic       trun  = 1'b0;
  logic       twxy, twdxy, pwxy, pwdxy, ten, pen, ts, won;
  logic [1:0] score;
  logic [1:0] shots;
  logic [6:0] outs;

  int checks = 0;
  int errors = 0;

  bit         load_q[$];
  logic [1:0] fire_q[$];
  logic [1:0] reload_q[$];
  logic [2:0] result_q[$];

  logic [1:0] fire_exp;
  logic [1:0] reload_exp;
  logic [2:0] result_exp;

  assign outs = {twxy, twdxy, pwxy, pwdxy, ten, pen, ts};

  always #5 clk = ~clk;

  game_round_controller #(
    .N_SHOTS(NS),
    .SHOT_WIDTH(2),
    .SCORE_WIDTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .sprite_target_within_screen(tw),
    .sprite_torpedo_within_screen(pw),
    .collision(coll),
    .end_of_game_timer_running(trun),
    .sprite_target_write_xy(twxy),
    .sprite_target_write_dxy(twdxy),
    .sprite_torpedo_write_xy(pwxy),
    .sprite_torpedo_write_dxy(pwdxy),
    .sprite_target_enable_update(ten),
    .sprite_torpedo_enable_update(pen),
    .end_of_game_timer_start(ts),
    .game_won(won),
    .score(score),
    .shots_left(shots)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // LOAD monitor
  always @(negedge clk) begin
    if (twxy) begin
      chk("load_expected", int'(load_q.size() != 0), 1);
      if (load_q.size() != 0) void'(load_q.pop_front());
      chk("load_outs", int'(outs), 'h78);
      @(negedge clk);
      chk("load_shots", int'(shots), NS);
      chk("aim_outs", int'(outs), 'h04);
      chk("load_won_clr", int'(won), 0);
    end
  end

  // FIRE monitor
  always @(negedge clk) begin
    if (pwdxy && !twxy) begin
      chk("fire_expected", int'(fire_q.size() != 0), 1);
      fire_exp = 2'd0;
      if (fire_q.size() != 0) fire_exp = fire_q.pop_front();
      chk("fire_outs", int'(outs), 'h0c);
      chk("fire_shots", int'(shots), int'(fire_exp));
      @(negedge clk);
      chk("flight_shots", int'(shots), int'(fire_exp) - 1);
      chk("flight_outs", int'(outs), 'h06);
    end
  end

  // RELOAD monitor
  always @(negedge clk) begin
    if (pwxy && !twxy) begin
      chk("reload_expected", int'(reload_q.size() != 0), 1);
      reload_exp = 2'd0;
      if (reload_q.size() != 0) reload_exp = reload_q.pop_front();
      chk("reload_outs", int'(outs), 'h14);
      chk("reload_shots", int'(shots), int'(reload_exp));
      @(negedge clk);
      chk("reaim_outs", int'(outs), 'h04);
    end
  end

  // Round result monitor
  always @(negedge clk) begin
    if (ts) begin
      chk("result_expected", int'(result_q.size() != 0), 1);
      result_exp = 3'd0;
      if (result_q.size() != 0) result_exp = result_q.pop_front();
      chk("result_outs", int'(outs), 'h01);
      @(negedge clk);
      chk("end_outs", int'(outs), 0);
      chk("result_won", int'(won), int'(result_exp[2]));
      chk("result_score", int'(score), int'(result_exp[1:0]));
    end
  end

  task automatic start_round();
    @(negedge clk);
    key = 1'b1;
    load_q.push_back(1'b1);
    repeat (2) @(negedge clk);
    key = 1'b0;
  endtask

  // Returns at the first FLIGHT cycle
  task automatic fire(input logic [1:0] s);
    @(negedge clk);
    key = 1'b1;
    fire_q.push_back(s);
    @(negedge clk);
    key = 1'b0;
    @(negedge clk);
  endtask

  // Called in the WON/LOST cycle after the result inputs are cleared
  task automatic finish_round(input bit press);
    @(negedge clk);
    trun = 1'b1;
    key  = press;
    repeat (10) @(negedge clk);
    chk("end_hold_outs", int'(outs), 0);
    trun = 1'b0;
    repeat (3) @(negedge clk);
    key = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", int'(outs), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_shots", int'(shots), 0);
    chk("rst_won", int'(won), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // start, then key held through AIM
    @(negedge clk);
    key = 1'b1;
    load_q.push_back(1'b1);
    repeat (22) @(negedge clk);
    chk("hold_no_fire", int'(outs), 'h04);
    chk("hold_shots", int'(shots), NS);
    key = 1'b0;
    @(negedge clk);

    // win
    fire(2'd3);
    coll = 1'b1;
    result_q.push_back({1'b1, 2'd1});
    @(negedge clk);
    coll = 1'b0;
    finish_round(1'b0);
    chk("idle_won_held", int'(won), 1);
    chk("idle_outs", int'(outs), 0);

    // three misses
    start_round();
    fire(2'd3);
    pw = 1'b0;
    reload_q.push_back(2'd2);
    @(negedge clk);
    pw = 1'b1;
    @(negedge clk);
    fire(2'd2);
    pw = 1'b0;
    reload_q.push_back(2'd1);
    @(negedge clk);
    pw = 1'b1;
    @(negedge clk);
    fire(2'd1);
    pw = 1'b0;
    result_q.push_back({1'b0, 2'd1});
    @(negedge clk);
    pw = 1'b1;
    finish_round(1'b0);
    chk("lost_won", int'(won), 0);

    // collision wins over both off-screen flags
    start_round();
    fire(2'd3);
    coll = 1'b1;
    tw   = 1'b0;
    pw   = 1'b0;
    result_q.push_back({1'b1, 2'd2});
    @(negedge clk);
    coll = 1'b0;
    tw   = 1'b1;
    pw   = 1'b1;
    finish_round(1'b0);

    // asynchronous reset mid-flight
    start_round();
    fire(2'd3);
    @(negedge clk);
    chk("pre_rst_score", int'(score), 2);
    #2 reset = 1'b0;
    #1;
    chk("async_outs", int'(outs), 0);
    chk("async_score", int'(score), 0);
    chk("async_shots", int'(shots), 0);
    chk("async_won", int'(won), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", int'(outs), 0);

    // saturation, key pressed during END
    for (int i = 0; i < 5; i++) begin
      start_round();
      fire(2'd3);
      coll = 1'b1;
      result_q.push_back({1'b1, (i < 3) ? 2'(i + 1) : 2'd3});
      @(negedge clk);
      coll = 1'b0;
      finish_round(1'b1);
    end
    chk("sat_score", int'(score), 3);

    repeat (3) @(negedge clk);
    chk("load_q_empty", load_q.size(), 0);
    chk("fire_q_empty", fire_q.size(), 0);
    chk("reload_q_empty", reload_q.size(), 0);
    chk("result_q_empty", result_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
